// File: rtl/cfg_reg_arbiter.sv
// Shared 16 x 8 configuration register file with two single-entry write buffers (I2C, host),
// round-robin commit arbitration, a host write lock and a control/status register at the top address.
module cfg_reg_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_data,
    input  logic              i2c_write_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_wr,
    output logic              host_busy,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              cfg_update,
    output logic [ADDR_W-1:0] cfg_addr
);

    localparam int unsigned NumRegs = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CtrlAddr = '1;

    logic [DATA_W-1:0] regs_q [NumRegs];

    logic              req_d_q;
    logic              pend_i2c_q, pend_i2c_d;
    logic              pend_host_q, pend_host_d;
    logic [ADDR_W-1:0] i2c_addr_q, host_addr_q;
    logic [DATA_W-1:0] i2c_data_q, host_data_q;
    logic              last_host_q, last_host_d;
    logic              ovf_i2c_q, ovf_i2c_d;
    logic              ovf_host_q, ovf_host_d;
    logic              lock_q, lock_d;
    logic              cfg_update_q, cfg_update_d;
    logic [ADDR_W-1:0] cfg_addr_q, cfg_addr_d;

    logic              i2c_rise, i2c_take, i2c_ovf;
    logic              host_take, host_ovf;
    logic              grant_i2c, grant_host, commit;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic              c_ctrl, c_drop, c_eff, wr_reg, wr_ctrl;

    always_comb begin
        grant_i2c  = pend_i2c_q && (!pend_host_q || last_host_q);
        grant_host = pend_host_q && !grant_i2c;
        commit     = grant_i2c || grant_host;
        c_addr     = grant_i2c ? i2c_addr_q : host_addr_q;
        c_data     = grant_i2c ? i2c_data_q : host_data_q;
        c_ctrl     = (c_addr == CtrlAddr);
        // Locked host writes still drain the buffer but leave no trace downstream.
        c_drop     = grant_host && lock_q && !c_ctrl;
        c_eff      = commit && !c_drop;
        wr_reg     = c_eff && !c_ctrl;
        wr_ctrl    = c_eff && c_ctrl;

        i2c_rise   = i2c_write_req && !req_d_q;
        i2c_take   = i2c_rise && (!pend_i2c_q || grant_i2c);
        i2c_ovf    = i2c_rise && !i2c_take;
        host_take  = host_wr && (!pend_host_q || grant_host);
        host_ovf   = host_wr && !host_take;

        pend_i2c_d  = i2c_take || (pend_i2c_q && !grant_i2c);
        pend_host_d = host_take || (pend_host_q && !grant_host);
        // A new overflow at the same edge as its clear wins.
        ovf_i2c_d   = i2c_ovf || (ovf_i2c_q && !(wr_ctrl && c_data[DATA_W-1]));
        ovf_host_d  = host_ovf || (ovf_host_q && !(wr_ctrl && c_data[DATA_W-2]));
        lock_d      = wr_ctrl ? c_data[0] : lock_q;
        last_host_d = commit ? grant_host : last_host_q;
        cfg_update_d = c_eff;
        cfg_addr_d   = c_eff ? c_addr : cfg_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d_q      <= 1'b0;
            pend_i2c_q   <= 1'b0;
            pend_host_q  <= 1'b0;
            last_host_q  <= 1'b1;
            ovf_i2c_q    <= 1'b0;
            ovf_host_q   <= 1'b0;
            lock_q       <= 1'b0;
            cfg_update_q <= 1'b0;
            cfg_addr_q   <= '0;
        end else begin
            req_d_q      <= i2c_write_req;
            pend_i2c_q   <= pend_i2c_d;
            pend_host_q  <= pend_host_d;
            last_host_q  <= last_host_d;
            ovf_i2c_q    <= ovf_i2c_d;
            ovf_host_q   <= ovf_host_d;
            lock_q       <= lock_d;
            cfg_update_q <= cfg_update_d;
            cfg_addr_q   <= cfg_addr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i2c_addr_q  <= '0;
            i2c_data_q  <= '0;
            host_addr_q <= '0;
            host_data_q <= '0;
        end else begin
            if (i2c_take) begin
                i2c_addr_q <= i2c_addr;
                i2c_data_q <= i2c_data;
            end
            if (host_take) begin
                host_addr_q <= host_addr;
                host_data_q <= host_data;
            end
        end
    end

    // The top entry is never written; its address decodes to the status word instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_reg) begin
            regs_q[c_addr] <= c_data;
        end
    end

    always_comb begin
        rd_data = regs_q[rd_addr];
        if (rd_addr == CtrlAddr) begin
            rd_data = '0;
            rd_data[DATA_W-1] = ovf_i2c_q;
            rd_data[DATA_W-2] = ovf_host_q;
            rd_data[0]        = lock_q;
        end
    end

    assign host_busy  = pend_host_q;
    assign cfg_update = cfg_update_q;
    assign cfg_addr   = cfg_addr_q;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Directed bench for cfg_reg_arbiter: per-cycle vector table plus hand sequences for
// asynchronous reset mid-operation and a spaced replay of an I2C byte stream.
module tb_cfg_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i2c_addr, host_addr, rd_addr, cfg_addr;
    logic [7:0] i2c_data, host_data, rd_data;
    logic       i2c_write_req, host_wr, host_busy, cfg_update;

    int n_tests = 0;
    int n_fail  = 0;

    always #2 clk = ~clk;

    cfg_reg_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i2c_addr      (i2c_addr),
        .i2c_data      (i2c_data),
        .i2c_write_req (i2c_write_req),
        .host_addr     (host_addr),
        .host_data     (host_data),
        .host_wr       (host_wr),
        .host_busy     (host_busy),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .cfg_update    (cfg_update),
        .cfg_addr      (cfg_addr)
    );

    typedef struct {
        logic       req;
        logic [3:0] ia;
        logic [7:0] id;
        logic       hw;
        logic [3:0] ha;
        logic [7:0] hd;
        logic [3:0] ra;
        logic       e_busy;
        logic       e_upd;
        logic [3:0] e_caddr;
        logic [7:0] e_rd;
    } vec_t;

    localparam int NumVec = 24;
    vec_t vecs [NumVec];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i2c_write_req = 1'b0;
        i2c_addr      = '0;
        i2c_data      = '0;
        host_wr       = 1'b0;
        host_addr     = '0;
        host_data     = '0;
    endtask

    initial begin
        int pulses;
        logic [3:0] seen_addr;
        logic [7:0] seen_data;

        // req ia  id     hw ha  hd     ra   busy upd caddr rd
        // Simultaneous writes right after reset: I2C first, host next cycle.
        vecs[0]  = '{1, 4'h2, 8'h11, 1, 4'h2, 8'h22, 4'h2, 1, 0, 4'h0, 8'h00};
        vecs[1]  = '{1, 4'h2, 8'h11, 0, 4'h0, 8'h00, 4'h2, 1, 1, 4'h2, 8'h11};
        vecs[2]  = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'h2, 0, 1, 4'h2, 8'h22};
        vecs[3]  = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'h2, 0, 0, 4'h2, 8'h22};
        // Single I2C write with request held for three cycles.
        vecs[4]  = '{1, 4'h7, 8'h03, 0, 4'h0, 8'h00, 4'h7, 0, 0, 4'h2, 8'h00};
        vecs[5]  = '{1, 4'h7, 8'h03, 0, 4'h0, 8'h00, 4'h7, 0, 1, 4'h7, 8'h03};
        vecs[6]  = '{1, 4'h7, 8'h03, 0, 4'h0, 8'h00, 4'h7, 0, 0, 4'h7, 8'h03};
        vecs[7]  = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'h7, 0, 0, 4'h7, 8'h03};
        // Three back-to-back host writes against an I2C write: third overflows.
        vecs[8]  = '{1, 4'h9, 8'h05, 1, 4'h4, 8'h01, 4'hF, 1, 0, 4'h7, 8'h00};
        vecs[9]  = '{1, 4'h9, 8'h05, 1, 4'h4, 8'h02, 4'hF, 1, 1, 4'h4, 8'h00};
        vecs[10] = '{0, 4'h0, 8'h00, 1, 4'h4, 8'h03, 4'hF, 1, 1, 4'h9, 8'h40};
        vecs[11] = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'h4, 0, 1, 4'h4, 8'h02};
        vecs[12] = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'h9, 0, 0, 4'h4, 8'h05};
        vecs[13] = '{0, 4'h0, 8'h00, 1, 4'hF, 8'h40, 4'hF, 1, 0, 4'h4, 8'h40};
        vecs[14] = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'hF, 0, 1, 4'hF, 8'h00};
        // Lock: host data write dropped silently, I2C write still lands.
        vecs[15] = '{0, 4'h0, 8'h00, 1, 4'hF, 8'h01, 4'hF, 1, 0, 4'hF, 8'h00};
        vecs[16] = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'hF, 0, 1, 4'hF, 8'h01};
        vecs[17] = '{0, 4'h0, 8'h00, 1, 4'h5, 8'hAA, 4'h5, 1, 0, 4'hF, 8'h00};
        vecs[18] = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'h5, 0, 0, 4'hF, 8'h00};
        vecs[19] = '{1, 4'h5, 8'h55, 0, 4'h0, 8'h00, 4'h5, 0, 0, 4'hF, 8'h00};
        vecs[20] = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'h5, 0, 1, 4'h5, 8'h55};
        vecs[21] = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'hF, 0, 0, 4'h5, 8'h01};
        // I2C unlocks through the control register.
        vecs[22] = '{1, 4'hF, 8'h80, 0, 4'h0, 8'h00, 4'hF, 0, 0, 4'h5, 8'h01};
        vecs[23] = '{0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 4'hF, 0, 1, 4'hF, 8'h00};

        rst = 1'b1;
        idle_inputs();
        rd_addr = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(host_busy), 32'h0);
        check("reset_update", 32'(cfg_update), 32'h0);
        check("reset_cfg_addr", 32'(cfg_addr), 32'h0);
        check("reset_status", 32'(rd_data), 32'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            @(negedge clk);
            i2c_write_req = vecs[i].req;
            i2c_addr      = vecs[i].ia;
            i2c_data      = vecs[i].id;
            host_wr       = vecs[i].hw;
            host_addr     = vecs[i].ha;
            host_data     = vecs[i].hd;
            rd_addr       = vecs[i].ra;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_busy", i), 32'(host_busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_update", i), 32'(cfg_update), 32'(vecs[i].e_upd));
            check($sformatf("v%0d_cfg_addr", i), 32'(cfg_addr), 32'(vecs[i].e_caddr));
            check($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].e_rd));
        end

        // Reset lands after a host capture but before its commit.
        @(negedge clk);
        idle_inputs();
        host_wr   = 1'b1;
        host_addr = 4'h3;
        host_data = 8'h77;
        rd_addr   = 4'h3;
        @(posedge clk);
        #1;
        check("rstmid_busy_before", 32'(host_busy), 32'h1);
        @(negedge clk);
        host_wr = 1'b0;
        rst     = 1'b1;
        #1;
        check("rstmid_busy_async", 32'(host_busy), 32'h0);
        check("rstmid_update_async", 32'(cfg_update), 32'h0);
        check("rstmid_cfg_addr_async", 32'(cfg_addr), 32'h0);
        check("rstmid_reg3_async", 32'(rd_data), 32'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_reg3_after", 32'(rd_data), 32'h00);
        check("rstmid_busy_after", 32'(host_busy), 32'h0);
        check("rstmid_update_after", 32'(cfg_update), 32'h0);
        rd_addr = 4'h7;
        #1;
        check("rstmid_reg7_cleared", 32'(rd_data), 32'h00);

        // Replay: four I2C bytes spaced 540 ns (135 cycles) apart, level held 20 cycles.
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            i2c_addr      = 4'(4'h8 + b);
            i2c_data      = 8'(8'h03 + b);
            i2c_write_req = 1'b1;
            pulses        = 0;
            seen_addr     = '0;
            seen_data     = '0;
            for (int c = 0; c < 135; c++) begin
                @(posedge clk);
                #1;
                if (cfg_update) begin
                    pulses++;
                    seen_addr = cfg_addr;
                    rd_addr   = cfg_addr;
                    #0;
                    seen_data = rd_data;
                end
                if (c == 20) i2c_write_req = 1'b0;
            end
            check($sformatf("replay%0d_pulses", b), 32'(pulses), 32'h1);
            check($sformatf("replay%0d_addr", b), 32'(seen_addr), 32'(4'h8 + b));
            check($sformatf("replay%0d_data", b), 32'(seen_data), 32'(8'h03 + b));
        end
        rd_addr = 4'hF;
        #1;
        check("replay_no_overflow", 32'(rd_data), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_reg_arbiter.md
# cfg_reg_arbiter

Configuration register-file controller for the FX2LP UAC2 CPLD. It shares a 16 x 8-bit configuration register file between two writers: the I2C slave interface (`i2c_if`) and a parallel host port driven by the FX2LP. Each writer gets a one-entry holding buffer, and commits are serialised with a round-robin grant. Committed writes are announced downstream with a one-cycle update strobe for the audio datapath.

## Interface
- `ADDR_W`, 4, register address width (16 registers).
- `DATA_W`, 8, register data width.

- `clk`  in  1  system clock; `i2c_if` runs on the same clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i2c_addr`  in  ADDR_W  register address from `i2c_if`.
- `i2c_data`  in  DATA_W  write data from `i2c_if`.
- `i2c_write_req`  in  1  write request from `i2c_if`; a level of any length, where only the rising edge counts.
- `host_addr`  in  ADDR_W  host register address.
- `host_data`  in  DATA_W  host write data.
- `host_wr`  in  1  host write strobe; every cycle it is high is a request.
- `host_busy`  out  1  host holding buffer is occupied.
- `rd_addr`  in  ADDR_W  read address.
- `rd_data`  out  DATA_W  combinational read of the register file.
- `cfg_update`  out  1  one-cycle pulse after each commit.
- `cfg_addr`  out  ADDR_W  address of the last commit; holds its value between commits.

## Operation
- **Reset:** all registers 0x00, both buffers empty, `last_grant` = host, `cfg_update` 0, `cfg_addr` 0, `host_busy` 0, both overflow flags 0, `lock` 0.
- **I2C capture:** `i2c_write_req` is registered as `req_d`. A request is taken at the edge where `i2c_write_req`=1 and `req_d`=0. At that edge, `i2c_addr` and `i2c_data` are latched and `pend_i2c` is set.
- **Host capture:** an edge with `host_wr`=1 latches `host_addr`/`host_data` and sets `pend_host`. `host_busy` = `pend_host`.
- **Overflow:** a request arriving while its buffer is full and not committing at the same edge is dropped. The matching sticky flag is set (`ovf_i2c` or `ovf_host`).
- **Arbitration:** at most one commit per edge.
  - Only one buffer pending: that buffer is granted.
  - Both pending: the one not equal to `last_grant` is granted.
  - `last_grant` updates on every commit.
- **Commit:** the granted entry is written into the register file and its buffer is cleared. If a new request for the same buffer arrives at that same edge, the new request is captured, the buffer stays full, and no overflow is flagged.
- **Lock:** while `lock`=1, host commits to addresses 0x0–0xE are discarded. The buffer is still cleared and `cfg_update` does not pulse. I2C commits are unaffected.
- **Register 0xF (control/status):**
  - Read value = {`ovf_i2c`, `ovf_host`, 5'b0, `lock`}.
  - A commit to 0xF sets `lock` from data bit 0.
  - Data bit 7 = 1 clears `ovf_i2c`; bit 6 = 1 clears `ovf_host` (write-1-to-clear). Bits 5..1 are ignored.
  - If an overflow occurs at the same edge as its clear, the set wins.
  - A host write to 0xF is always allowed, even when locked.
- `rd_data` reflects a commit from the edge at which it happens.

## Timing
- I2C rising edge sampled at edge k → captured at k → committed at k+1 if granted → `cfg_update`=1 and `cfg_addr` valid from k+1 to k+2.
- Host write at edge k → `host_busy`=1 after k → commit at k+1 (no contention) → `host_busy`=0 after k+1, unless refilled at k+1.
- Contention adds exactly one cycle of latency to the loser. Worst-case latency from capture to commit is 2 edges.
- Back-to-back `host_wr` on consecutive cycles is sustained at one write per cycle only while the host wins arbitration. Otherwise the second write overflows.
- Reset asserted mid-operation: pending entries are discarded, no commit occurs, and outputs return to reset values asynchronously.
- `i2c_write_req` held high for many cycles produces a single request.

## Test plan
- **Single I2C write:** `i2c_addr`=0x7, `i2c_data`=0x03, req high for 3 cycles → reg 0x7 = 0x03 two edges after the rise; exactly one `cfg_update` pulse with `cfg_addr`=0x7.
- **Simultaneous writes:** I2C write 0x2←0x11 and host write 0x2←0x22 at the same edge after reset → I2C commits first, host one cycle later; final reg 0x2 = 0x22; two `cfg_update` pulses.
- **Host overflow:** host writes to 0x4 on three consecutive cycles while an I2C write arrives at the first one → `ovf_host`=1; reg 0xF reads 0x40; host write 0xF←0x40 clears it to 0x00.
- **Lock:** host writes 0xF←0x01, then host writes 0x5←0xAA → reg 0x5 stays 0x00 and no pulse is produced. An I2C write 0x5←0x55 then gives reg 0x5 = 0x55.
- **Reset mid-operation:** raise `rst` one cycle after a host write, before its commit → reg unchanged at 0x00, `host_busy`=0, `cfg_update`=0.
- **Replay of the I2C sequence:** a register-address byte followed by data bytes 0x03..0x06 as four requests spaced 540 ns apart on a 4 ns clock → four commits, each with correct address and data, and no overflow.
